frame_tx_queue: RTL and testbench

- Ingress frame queue between the operator front end (switch/keypad/button conditioning) and the L2 switch fabric.
- Captures one frame per `add_pulse` as {DST, SRC, payload} and buffers frames in FIFO order.
- On `send_pulse`, drains every queued frame to the fabric over a valid/ready handshake, with a fixed inter-frame gap.
- Tags each frame with its ingress port, derived from the SRC node address.

---
 rtl/l2sw_pkg.sv | 31 +++
 rtl/frame_tx_queue_sync_fifo.sv | 74 +++++++
 rtl/frame_tx_queue.sv | 160 ++++++++++++++++
 tb/tb_frame_tx_queue.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2sw_pkg.sv
// Shared L2 switch definitions: node addresses, frame layout and address helpers.
package l2sw_pkg;

  localparam int ADDR_W    = 4;
  localparam int PAYLOAD_W = 4;
  localparam int NUM_PORTS = 4;

  localparam logic [ADDR_W-1:0] NODE_A = 4'hA;
  localparam logic [ADDR_W-1:0] NODE_B = 4'hB;
  localparam logic [ADDR_W-1:0] NODE_C = 4'hC;
  localparam logic [ADDR_W-1:0] NODE_D = 4'hD;

  typedef struct packed {
    logic [ADDR_W-1:0]    dst;
    logic [ADDR_W-1:0]    src;
    logic [PAYLOAD_W-1:0] payload;
  } frame_t;

  // Only nodes A..D exist on this switch.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return (addr >= NODE_A) && (addr <= NODE_D);
  endfunction

  // Node A sits on port 0, B on port 1, and so on.
  function automatic logic [1:0] addr_to_port(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] offset;
    offset = addr - NODE_A;
    return offset[1:0];
  endfunction

endpackage

// File: rtl/frame_tx_queue_sync_fifo.sv
// Synchronous FIFO with registered count/full/empty and a look-ahead of the
// entry behind the head, so a consumer can chain back-to-back reads.
module sync_fifo #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] rd_data_next,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;

  // Pointer and occupancy update; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    do_pop   = pop && !empty_q;
    do_push  = push && (!full_q || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage write.
  // NOTE: the array has no reset; contents are meaningless until written and the pointers guard every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign rd_data      = mem[rd_ptr_q];
  assign rd_data_next = mem[rd_ptr_q + PTR_W'(1)];
  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;

endmodule

// File: rtl/frame_tx_queue.sv
// Ingress frame queue: validates and buffers operator frames, then drains the
// whole queue to the switch fabric on a send strobe with a fixed inter-frame gap.
module frame_tx_queue #(
  parameter  int DEPTH     = 8,
  parameter  int ADDR_W    = 4,
  parameter  int PAYLOAD_W = 4,
  parameter  int IFG       = 1,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 add_pulse,
  input  logic                 send_pulse,
  input  logic [ADDR_W-1:0]    in_dst,
  input  logic [ADDR_W-1:0]    in_src,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [ADDR_W-1:0]    tx_dst,
  output logic [ADDR_W-1:0]    tx_src,
  output logic [PAYLOAD_W-1:0] tx_payload,
  output logic [1:0]           tx_port,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 overflow,
  output logic                 addr_err
);
  import l2sw_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

  localparam int GAP_W = (IFG > 1) ? $clog2(IFG) : 1;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             tx_valid_q, tx_valid_d;
  frame_t           tx_frame_q, tx_frame_d;
  logic [1:0]       tx_port_q, tx_port_d;
  logic             overflow_q, overflow_d, addr_err_q, addr_err_d;

  frame_t           in_frame, fifo_head, fifo_next, load_frame;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             addr_ok, push, pop, send_ok, load;

  sync_fifo #(.WIDTH($bits(frame_t)), .DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .push_data    (in_frame),
    .pop          (pop),
    .rd_data      (fifo_head),
    .rd_data_next (fifo_next),
    .count        (fifo_count),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

  // Add validation, drain FSM next state, output register loads and sticky flags.
  // When the queue is about to be empty, a same-cycle add is presented directly.
  always_comb begin
    in_frame   = '{dst: in_dst, src: in_src, payload: in_payload};
    addr_ok    = addr_valid(in_src) && addr_valid(in_dst);
    pop        = (state_q == S_PRESENT) && tx_ready;
    push       = add_pulse && addr_ok && (!fifo_full || pop);
    send_ok    = (state_q == S_IDLE) && send_pulse && !fifo_empty;
    state_d    = state_q;
    gap_d      = gap_q;
    tx_valid_d = tx_valid_q;
    tx_frame_d = tx_frame_q;
    tx_port_d  = tx_port_q;
    load       = 1'b0;
    load_frame = fifo_head;

    case (state_q)
      S_IDLE: begin
        if (send_ok) begin
          state_d = S_PRESENT;
          load    = 1'b1;
        end
      end
      S_PRESENT: begin
        if (pop) begin
          if (IFG > 0) begin
            state_d    = S_GAP;
            gap_d      = '0;
            tx_valid_d = 1'b0;
          end else if ((fifo_count > CNT_W'(1)) || push) begin
            load       = 1'b1;
            load_frame = (fifo_count > CNT_W'(1)) ? fifo_next : in_frame;
          end else begin
            state_d    = S_IDLE;
            tx_valid_d = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(IFG - 1)) begin
          if (!fifo_empty || push) begin
            state_d    = S_PRESENT;
            load       = 1'b1;
            load_frame = !fifo_empty ? fifo_head : in_frame;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      tx_valid_d = 1'b1;
      tx_frame_d = load_frame;
      tx_port_d  = addr_to_port(load_frame.src);
    end

    overflow_d = send_ok ? 1'b0 : overflow_q;
    addr_err_d = send_ok ? 1'b0 : addr_err_q;
    if (add_pulse && !addr_ok)                          addr_err_d = 1'b1;
    if (add_pulse && addr_ok && fifo_full && !pop)      overflow_d = 1'b1;
  end

  // FSM state, presented frame and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gap_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_frame_q <= '0;
      tx_port_q  <= '0;
      overflow_q <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      tx_valid_q <= tx_valid_d;
      tx_frame_q <= tx_frame_d;
      tx_port_q  <= tx_port_d;
      overflow_q <= overflow_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_dst     = tx_frame_q.dst;
  assign tx_src     = tx_frame_q.src;
  assign tx_payload = tx_frame_q.payload;
  assign tx_port    = tx_port_q;
  assign count      = fifo_count;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = overflow_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_frame_tx_queue.sv
// Self-checking bench for frame_tx_queue: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based reference model.
module tb_frame_tx_queue;

  localparam int DEPTH = 8;
  localparam int IFG   = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          add_pulse, send_pulse, tx_ready;
  logic [3:0]    in_dst, in_src, in_payload;
  logic          tx_valid;
  logic [3:0]    tx_dst, tx_src, tx_payload;
  logic [1:0]    tx_port;
  logic [CW-1:0] count;
  logic          full, empty, busy, overflow, addr_err;

  frame_tx_queue #(.DEPTH(DEPTH), .ADDR_W(4), .PAYLOAD_W(4), .IFG(IFG)) dut (
    .clk        (clk),
    .rst        (rst),
    .add_pulse  (add_pulse),
    .send_pulse (send_pulse),
    .in_dst     (in_dst),
    .in_src     (in_src),
    .in_payload (in_payload),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_dst     (tx_dst),
    .tx_src     (tx_src),
    .tx_payload (tx_payload),
    .tx_port    (tx_port),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .overflow   (overflow),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Handshake log: {dst, src, payload, port}; sampled mid-cycle, accepted on the next rising edge.
  logic [13:0] hs_log[$];
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) hs_log.push_back({tx_dst, tx_src, tx_payload, tx_port});
  end

  function automatic logic [1:0] port_of(input logic [3:0] src);
    int p;
    p = int'(src) - 10;
    return 2'(p);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input logic ready);
    add_pulse = 1'b0; send_pulse = 1'b0; tx_ready = ready;
    in_dst = 4'h0; in_src = 4'h0; in_payload = 4'h0;
  endtask

  task automatic pulse_reset(input logic ready);
    idle_inputs(ready);
    @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    hs_log.delete();
  endtask

  task automatic add(input logic [3:0] d, input logic [3:0] s, input logic [3:0] p);
    add_pulse = 1'b1; in_dst = d; in_src = s; in_payload = p;
    tick();
    add_pulse = 1'b0;
  endtask

  typedef struct {
    logic       add, send, ready;
    logic [3:0] dst, src, pl;
    logic       e_valid, e_busy, e_ovf, e_aerr;
    int         e_count;
    logic [3:0] e_dst, e_src, e_pl;
    logic [1:0] e_port;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic [11:0] m_q[$];
  bit          m_busy, m_valid, m_ovf, m_aerr;
  int          m_gap;

  function automatic bit node_ok(input logic [3:0] a);
    return (a >= 4'hA) && (a <= 4'hD);
  endfunction

  task automatic model_edge();
    bit pop, ok, push, send_acc;
    pop      = m_valid && tx_ready;
    ok       = node_ok(in_src) && node_ok(in_dst);
    push     = add_pulse && ok && ((m_q.size() < DEPTH) || pop);
    send_acc = !m_busy && send_pulse && (m_q.size() > 0);
    if (send_acc) begin m_ovf = 0; m_aerr = 0; end
    if (add_pulse && !ok) m_aerr = 1;
    if (add_pulse && ok && !push) m_ovf = 1;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back({in_dst, in_src, in_payload});
    if (send_acc) begin
      m_busy = 1; m_valid = 1;
    end else if (pop) begin
      m_valid = 0;
      m_gap   = IFG;
      if (IFG == 0) begin
        if (m_q.size() > 0) m_valid = 1; else m_busy = 0;
      end
    end else if (m_busy && !m_valid) begin
      m_gap--;
      if (m_gap <= 0) begin
        if (m_q.size() > 0) m_valid = 1; else m_busy = 0;
      end
    end
  endtask

  initial begin
    int n;
    logic [13:0] e;
    rst = 1'b1;
    idle_inputs(1'b1);
    repeat (2) @(posedge clk);
    #3;
    check("reset_status", {tx_valid, busy, full, empty, overflow, addr_err, count},
          {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CW'(0)});
    check("reset_fields", {tx_dst, tx_src, tx_payload, tx_port}, 14'h0);
    rst = 1'b0;
    hs_log.delete();

    // ---- Directed vector table: basic drain with gaps, then address errors ----
    //            add send rdy dst    src    pl     val bsy ovf aer cnt  dst   src   pl   port
    vecs.push_back('{1, 0, 1, 4'hC, 4'hA, 4'h5, 0, 0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{1, 0, 1, 4'hD, 4'hB, 4'h5, 0, 0, 0, 0, 2, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{1, 0, 1, 4'hA, 4'hC, 4'h5, 0, 0, 0, 0, 3, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{0, 1, 1, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 3, 4'hC, 4'hA, 4'h5, 2'd0});
    vecs.push_back('{0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 2, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 2, 4'hD, 4'hB, 4'h5, 2'd1});
    vecs.push_back('{0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 1, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{0, 0, 1, 4'h0, 4'h0, 4'h0, 1, 1, 0, 0, 1, 4'hA, 4'hC, 4'h5, 2'd2});
    vecs.push_back('{0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{1, 0, 1, 4'hB, 4'h3, 4'h1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{1, 0, 1, 4'hF, 4'hA, 4'h2, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{0, 1, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 2'd0});
    vecs.push_back('{0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 2'd0});

    foreach (vecs[i]) begin
      add_pulse = vecs[i].add; send_pulse = vecs[i].send; tx_ready = vecs[i].ready;
      in_dst = vecs[i].dst; in_src = vecs[i].src; in_payload = vecs[i].pl;
      tick();
      check($sformatf("vec%0d_status", i),
            {tx_valid, busy, full, empty, overflow, addr_err, count},
            {vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_count == DEPTH, vecs[i].e_count == 0,
             vecs[i].e_ovf, vecs[i].e_aerr, CW'(vecs[i].e_count)});
      if (vecs[i].e_valid)
        check($sformatf("vec%0d_fields", i), {tx_dst, tx_src, tx_payload, tx_port},
              {vecs[i].e_dst, vecs[i].e_src, vecs[i].e_pl, vecs[i].e_port});
    end
    idle_inputs(1'b1);
    check("vec_hs_count", hs_log.size(), 3);

    // ---- Backpressure: fields frozen while tx_ready is low ----
    pulse_reset(1'b0);
    add(4'hB, 4'hA, 4'h3);
    add(4'hA, 4'hB, 4'h7);
    send_pulse = 1'b1; tick(); send_pulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i), {tx_valid, tx_dst, tx_src, tx_payload, tx_port, count},
            {1'b1, 4'hB, 4'hA, 4'h3, 2'd0, CW'(2)});
      tick();
    end
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    check("bp_count_after_pop", count, CW'(1));
    repeat (4) tick();
    check("bp_single_pop", hs_log.size(), 1);
    check("bp_next_fields", {tx_valid, tx_dst, tx_src, tx_payload, tx_port},
          {1'b1, 4'hA, 4'hB, 4'h7, 2'd1});

    // ---- Fill beyond capacity ----
    pulse_reset(1'b0);
    for (int i = 0; i <= DEPTH; i++) add(4'hC, 4'hD, 4'(i));
    check("fill_status", {full, empty, overflow, count}, {1'b1, 1'b0, 1'b1, CW'(DEPTH)});
    tx_ready = 1'b1; send_pulse = 1'b1; tick(); send_pulse = 1'b0;
    check("fill_ovf_cleared", overflow, 1'b0);
    repeat (2 * DEPTH * (1 + IFG) + 2) tick();
    check("fill_drain_len", hs_log.size(), DEPTH);
    for (int i = 0; i < DEPTH; i++)
      if (i < hs_log.size())
        check($sformatf("fill_frame%0d", i), hs_log[i], {4'hC, 4'hD, 4'(i), 2'd3});
    check("fill_end", {busy, empty}, 2'b01);

    // ---- Add during drain, same-cycle add and pop ----
    pulse_reset(1'b1);
    add(4'hC, 4'hA, 4'h1);
    add(4'hD, 4'hB, 4'h2);
    add(4'hA, 4'hC, 4'h3);
    send_pulse = 1'b1; tick(); send_pulse = 1'b0;
    add(4'hB, 4'hD, 4'h4);
    check("ad_count_add_pop", count, CW'(3));
    repeat (12) tick();
    check("ad_hs_count", hs_log.size(), 4);
    e = (hs_log.size() > 0) ? hs_log[hs_log.size() - 1] : 14'h0;
    check("ad_last_frame", e, {4'hB, 4'hD, 4'h4, 2'd3});
    check("ad_end", {busy, empty}, 2'b01);

    // ---- Asynchronous reset mid-drain ----
    pulse_reset(1'b1);
    add(4'hC, 4'hA, 4'h1);
    add(4'hD, 4'hB, 4'h2);
    add(4'hA, 4'hC, 4'h3);
    send_pulse = 1'b1; tick(); send_pulse = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("rst_async", {tx_valid, busy, empty, count}, {1'b0, 1'b0, 1'b1, CW'(0)});
    @(posedge clk);
    #3 rst = 1'b0;
    n = hs_log.size();
    repeat (10) tick();
    check("rst_no_resend", hs_log.size() - n, 0);
    check("rst_quiet", {tx_valid, busy}, 2'b00);

    // ---- Randomized run against the reference model ----
    pulse_reset(1'b1);
    m_q.delete(); m_busy = 0; m_valid = 0; m_ovf = 0; m_aerr = 0; m_gap = 0;
    for (int c = 0; c < 800; c++) begin
      add_pulse  = ($urandom_range(0, 2) == 0);
      send_pulse = ($urandom_range(0, 11) == 0);
      tx_ready   = (c < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      in_dst     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(10 + $urandom_range(0, 3));
      in_src     = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'(10 + $urandom_range(0, 3));
      in_payload = 4'($urandom);
      model_edge();
      tick();
      check($sformatf("rnd%0d_status", c),
            {tx_valid, busy, full, empty, overflow, addr_err, count},
            {m_valid, m_busy, m_q.size() == DEPTH, m_q.size() == 0, m_ovf, m_aerr, CW'(m_q.size())});
      if (m_valid && m_q.size() > 0)
        check($sformatf("rnd%0d_head", c), {tx_dst, tx_src, tx_payload, tx_port},
              {m_q[0], port_of(m_q[0][7:4])});
    end
    idle_inputs(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
